// File: rtl/uart_matmul_pkg.sv
// Shared types and constants for the UART matrix multiplier.
// Holds the FSM state enum, size limits and the baud divisor helper.
package uart_matmul_pkg;

    localparam int MAX_N = 3;
    localparam int RES_W = 24;

    typedef enum logic [2:0] {
        WAIT_N,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        SEND
    } state_t;

    // Clocks per bit for the selected baud rate, truncated.
    function automatic int unsigned baud_div(
        input int unsigned clk_hz,
        input logic [1:0]  sel
    );
        int unsigned d;
        case (sel)
            2'b00:   d = clk_hz / 4800;
            2'b01:   d = clk_hz / 9600;
            2'b10:   d = clk_hz / 19200;
            default: d = clk_hz / 115200;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/uart_matmul_phy.sv
// UART phy: baud divider, 8N1 receiver and transmitter.
// Ports: clk, rst, rx/tx lines, b_sel, rx_data/rx_valid, tx_data/tx_start/tx_busy.
module uart_phy #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [1:0] b_sel,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy
);
    import uart_matmul_pkg::*;

    localparam int CW = $clog2(CLK_HZ / 4800 + 1);

    logic [CW-1:0] div_sel;
    logic          rx_s1, rx_s2, rx_s3, fall;
    logic          rx_act;
    logic [CW-1:0] rx_div, rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          tx_act, tx_end;
    logic [CW-1:0] tx_div, tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_sh;

    assign div_sel = CW'(baud_div(CLK_HZ, b_sel));
    assign fall    = rx_s3 & ~rx_s2;
    assign rx_data = rx_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // Bit 0 is the half-bit start re-check; 1..8 data; 9 stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_act   <= 1'b0;
            rx_div   <= '0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (!rx_act) begin
                if (fall) begin
                    rx_act <= 1'b1;
                    rx_div <= div_sel;
                    rx_cnt <= div_sel >> 1;
                    rx_bit <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else begin
                rx_cnt <= rx_div - 1'b1;
                rx_bit <= rx_bit + 1'b1;
                if (rx_bit == 4'd0) begin
                    if (rx_s2) begin
                        rx_act <= 1'b0;
                        rx_bit <= '0;
                    end
                end else if (rx_bit == 4'd9) begin
                    rx_act   <= 1'b0;
                    rx_bit   <= '0;
                    rx_valid <= rx_s2;
                end else begin
                    rx_sh <= {rx_s2, rx_sh[7:1]};
                end
            end
        end
    end

    // Busy drops in the last stop cycle so a new byte follows seamlessly.
    assign tx_end  = tx_act && tx_cnt == '0 && tx_bit == 4'd9;
    assign tx_busy = tx_act && !tx_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx     <= 1'b1;
            tx_act <= 1'b0;
            tx_div <= '0;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '1;
        end else if (tx_start && !tx_busy) begin
            tx     <= 1'b0;
            tx_act <= 1'b1;
            tx_div <= div_sel;
            tx_cnt <= div_sel - 1'b1;
            tx_bit <= '0;
            tx_sh  <= {1'b1, tx_data};
        end else if (tx_act) begin
            if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - 1'b1;
            end else if (tx_bit == 4'd9) begin
                tx_act <= 1'b0;
            end else begin
                tx_cnt <= tx_div - 1'b1;
                tx_bit <= tx_bit + 1'b1;
                tx     <= tx_sh[0];
                tx_sh  <= {1'b1, tx_sh[8:1]};
            end
        end
    end

endmodule

// File: rtl/uart_matmul_top.sv
// UART matrix multiplier: loads N, A, B over rx, sends C = A x B on tx.
// Ports: clk, rst (async high), rx, b_sel baud select, tx.
module uart_matmul_top #(
    parameter int CLK_HZ = 50000000,
    parameter int MAX_N  = uart_matmul_pkg::MAX_N,
    parameter int RES_W  = uart_matmul_pkg::RES_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [1:0] b_sel,
    output logic       tx
);
    import uart_matmul_pkg::*;

    localparam int IW = $clog2(MAX_N + 1);

    state_t           state, state_nx;
    logic [IW-1:0]    n_q, nm1, ci, cj, ck;
    logic [1:0]       bidx;
    logic             last_sent;
    logic [RES_W-1:0] acc, sum, c_sel;
    logic [15:0]      prod;
    logic [7:0]       rx_data, tx_data;
    logic             rx_valid, tx_start, tx_busy;
    logic             n_ok, ld_last, mac_last, tx_take;

    logic [7:0]       a_mem [MAX_N][MAX_N];
    logic [7:0]       b_mem [MAX_N][MAX_N];
    logic [RES_W-1:0] c_mem [MAX_N][MAX_N];

    uart_phy #(.CLK_HZ(CLK_HZ)) u_phy (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .b_sel    (b_sel),
        .tx       (tx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

    assign nm1      = n_q - 1'b1;
    assign n_ok     = rx_data != 8'd0 && rx_data <= 8'(MAX_N);
    assign ld_last  = ci == nm1 && cj == nm1;
    assign mac_last = ld_last && ck == nm1;
    assign tx_take  = tx_start && !tx_busy;
    assign prod     = a_mem[ci][ck] * b_mem[ck][cj];
    assign sum      = (ck == '0 ? '0 : acc) + RES_W'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_N;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            WAIT_N:  if (rx_valid && n_ok)    state_nx = LOAD_A;
            LOAD_A:  if (rx_valid && ld_last) state_nx = LOAD_B;
            LOAD_B:  if (rx_valid && ld_last) state_nx = COMPUTE;
            COMPUTE: if (mac_last)            state_nx = SEND;
            SEND:    if (last_sent && !tx_busy) state_nx = WAIT_N;
            default: state_nx = WAIT_N;
        endcase
    end

    always_comb begin
        tx_start = state == SEND && !last_sent;
        c_sel    = c_mem[ci][cj];
        tx_data  = c_sel[7:0];
        unique case (bidx)
            2'd0:    tx_data = c_sel[23:16];
            2'd1:    tx_data = c_sel[15:8];
            default: tx_data = c_sel[7:0];
        endcase
    end

    // Counters wrap to zero at the end of each phase, ready for the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q       <= '0;
            ci        <= '0;
            cj        <= '0;
            ck        <= '0;
            bidx      <= '0;
            acc       <= '0;
            last_sent <= 1'b0;
        end else begin
            unique case (state)
                WAIT_N: begin
                    last_sent <= 1'b0;
                    if (rx_valid && n_ok) n_q <= rx_data[IW-1:0];
                end
                LOAD_A, LOAD_B: begin
                    if (rx_valid) begin
                        if (cj == nm1) begin
                            cj <= '0;
                            ci <= ld_last ? '0 : ci + 1'b1;
                        end else begin
                            cj <= cj + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    acc <= sum;
                    if (ck == nm1) begin
                        ck <= '0;
                        if (cj == nm1) begin
                            cj <= '0;
                            ci <= ld_last ? '0 : ci + 1'b1;
                        end else begin
                            cj <= cj + 1'b1;
                        end
                    end else begin
                        ck <= ck + 1'b1;
                    end
                end
                SEND: begin
                    if (tx_take) begin
                        if (bidx == 2'd2) begin
                            bidx      <= '0;
                            last_sent <= ld_last;
                            if (cj == nm1) begin
                                cj <= '0;
                                ci <= ld_last ? '0 : ci + 1'b1;
                            end else begin
                                cj <= cj + 1'b1;
                            end
                        end else begin
                            bidx <= bidx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Matrix storage carries no reset; contents are rewritten each job.
    always_ff @(posedge clk) begin
        if (state == LOAD_A && rx_valid) a_mem[ci][cj] <= rx_data;
        if (state == LOAD_B && rx_valid) b_mem[ci][cj] <= rx_data;
        if (state == COMPUTE && ck == nm1) c_mem[ci][cj] <= sum;
    end

endmodule

// File: tb/tb_uart_matmul_top.sv
// Directed bench for uart_matmul_top.
// Drives UART frames on rx and decodes tx into a byte queue.
module tb_uart_matmul_top;

    localparam int CLK_HZ = 460800;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [1:0] b_sel = 2'b01;
    logic       tx;

    int checks = 0;
    int failures = 0;
    int bit_clk = CLK_HZ / 9600;
    int stop_errs = 0;

    logic [7:0] rxq[$];
    logic [7:0] stim[$];
    logic [7:0] expv[$];

    uart_matmul_top #(.CLK_HZ(CLK_HZ)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .b_sel (b_sel),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_baud(input logic [1:0] sel);
        b_sel = sel;
        case (sel)
            2'b00:   bit_clk = CLK_HZ / 4800;
            2'b01:   bit_clk = CLK_HZ / 9600;
            2'b10:   bit_clk = CLK_HZ / 19200;
            default: bit_clk = CLK_HZ / 115200;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (bit_clk) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rx = d[b];
            repeat (bit_clk) @(negedge clk);
        end
        rx = stop;
        repeat (bit_clk) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic collect(input string tag);
        int budget;
        logic [31:0] got;
        budget = (expv.size() * 10 + 20) * bit_clk + 200;
        while (rxq.size() < expv.size() && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({tag, "_timeout"}, 32'(budget > 0), 32'd1);
        repeat (15 * bit_clk) @(negedge clk);
        check({tag, "_count"}, rxq.size(), expv.size());
        foreach (expv[i]) begin
            got = (i < rxq.size()) ? 32'(rxq[i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_b%0d", tag, i), got, 32'(expv[i]));
        end
    endtask

    task automatic run_case(input string tag, input logic [1:0] sel);
        set_baud(sel);
        rxq.delete();
        foreach (stim[i]) send_byte(stim[i], 1'b1);
        collect(tag);
    endtask

    // tx decoder: centre-samples each frame and queues the byte.
    initial begin
        logic [7:0] v;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                repeat (bit_clk / 2) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int b = 0; b < 8; b++) begin
                        repeat (bit_clk) @(negedge clk);
                        v[b] = tx;
                    end
                    repeat (bit_clk) @(negedge clk);
                    if (tx !== 1'b1) stop_errs++;
                    rxq.push_back(v);
                end
            end
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        check("reset_tx", tx, 1);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_tx", tx, 1);

        stim = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                 8'h05, 8'h06, 8'h07, 8'h08};
        expv = '{8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h16,
                 8'h00, 8'h00, 8'h2B, 8'h00, 8'h00, 8'h32};
        run_case("n2", 2'b01);

        stim = '{8'h03,
                 8'h01, 8'h02, 8'h03, 8'h04, 8'h03,
                 8'h04, 8'h04, 8'h03, 8'h04,
                 8'h05, 8'h06, 8'h07, 8'h08, 8'h07,
                 8'h08, 8'h08, 8'h07, 8'h08};
        expv = '{8'h00, 8'h00, 8'h2D, 8'h00, 8'h00, 8'h29,
                 8'h00, 8'h00, 8'h2F, 8'h00, 8'h00, 8'h4C,
                 8'h00, 8'h00, 8'h49, 8'h00, 8'h00, 8'h54,
                 8'h00, 8'h00, 8'h4C, 8'h00, 8'h00, 8'h49,
                 8'h00, 8'h00, 8'h54};
        run_case("n3", 2'b01);

        stim = '{8'h01, 8'hFF, 8'hFF};
        expv = '{8'h00, 8'hFE, 8'h01};
        run_case("n1_max", 2'b00);

        stim.delete();
        stim.push_back(8'h03);
        repeat (18) stim.push_back(8'hFF);
        expv.delete();
        repeat (9) begin
            expv.push_back(8'h02);
            expv.push_back(8'hFA);
            expv.push_back(8'h03);
        end
        run_case("n3_max", 2'b10);

        stim = '{8'h00, 8'h07, 8'h01, 8'h03, 8'h05};
        expv = '{8'h00, 8'h00, 8'h0F};
        run_case("illegal", 2'b10);

        set_baud(2'b10);
        rxq.delete();
        send_byte(8'h02, 1'b0);
        repeat (3 * bit_clk) @(negedge clk);
        stim = '{8'h01, 8'h03, 8'h05};
        foreach (stim[i]) send_byte(stim[i], 1'b1);
        collect("framing");

        set_baud(2'b01);
        rxq.delete();
        stim = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
        foreach (stim[i]) send_byte(stim[i], 1'b1);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_tx", tx, 1);
        rst = 1'b0;
        repeat (20 * bit_clk) @(negedge clk);
        check("midrst_idle_tx", tx, 1);
        check("midrst_no_out", rxq.size(), 0);

        stim = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                 8'h05, 8'h06, 8'h07, 8'h08};
        expv = '{8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h16,
                 8'h00, 8'h00, 8'h2B, 8'h00, 8'h00, 8'h32};
        run_case("after_rst", 2'b01);

        run_case("n2_fast", 2'b11);

        check("stop_bits", stop_errs, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_matmul_top.md
Name: uart_matmul_top

Overview:
- Top level of the UART matrix-multiplier FPGA design.
- Receives a matrix dimension N, then matrix A and matrix B, over a UART RX line. All elements are unsigned 8-bit, sent row-major.
- Computes C = A x B with a sequential multiply-accumulate, then transmits every C element on the UART TX line.
- Baud rate is selected at run time by the b_sel input.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- MAX_N, 3, largest supported matrix dimension.
- RES_W, 24, width of each result element, sent as 3 bytes.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  UART receive line; idle high; 8N1, LSB first.
- b_sel  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=115200.
- tx  output  1  UART transmit line; idle high; 8N1, LSB first.

Behaviour:
- Reset (asynchronous, any state):
  - tx=1; FSM goes to WAIT_N; all counters, accumulator and RX/TX shifters clear.
  - Matrix contents become don't-care.
- Baud:
  - Divisor = CLK_HZ/baud, integer truncated (9600 -> 5208 clocks/bit).
  - b_sel is sampled at each start-bit detection (RX) and each byte launch (TX).
  - Changing b_sel mid-frame does not affect the frame in progress.
- RX:
  - A start bit is a falling edge on rx, taken after a 2-flop synchronizer.
  - Start bit is re-checked at half-bit; if rx is high there, the event is treated as a glitch and ignored.
  - Data bits are sampled at bit centres.
  - Stop bit sampled low = framing error: the byte is discarded and the FSM does not advance.
  - A valid byte gives a 1-cycle rx_valid pulse.
- FSM states: WAIT_N -> LOAD_A -> LOAD_B -> COMPUTE -> SEND -> WAIT_N.
  - WAIT_N: first valid byte is N. If 1 <= N <= MAX_N, latch N and go to LOAD_A; otherwise ignore the byte and stay.
  - LOAD_A: store N*N bytes into A[i][k], row-major; then go to LOAD_B.
  - LOAD_B: store N*N bytes into B[k][j], row-major; then go to COMPUTE.
  - COMPUTE: one MAC per clock, acc += A[i][k]*B[k][j].
    - Loop order: i outer, j middle, k inner.
    - acc clears at k=0; C[i][j] is written after k=N-1.
    - Takes N^3 cycles, after which the FSM goes to SEND.
  - SEND: transmit C row-major. Each element is 3 bytes, MSB first (bits 23:16, 15:8, 7:0).
    - Byte launches are back-to-back: the next start bit immediately follows the previous stop bit.
    - After the last byte's stop bit completes, return to WAIT_N.
- RX bytes that arrive during COMPUTE or SEND are dropped.
- Arithmetic:
  - 8x8 unsigned -> 16-bit product, zero-extended into a 24-bit accumulator.
  - Worst case 3*255*255 = 195075 fits in 24 bits, so no overflow or saturation is possible.
- TX line holds 1 whenever no byte is being transmitted.

Decomposition:
- Package uart_matmul_pkg holds:
  - FSM state enum.
  - Baud divisor constants, a function of CLK_HZ.
  - MAX_N and RES_W.
- One sub-module, uart_phy: baud divider plus RX and TX shifters.
  - RX side: rx_data, rx_valid.
  - TX side: tx_data, tx_start, tx_busy.
- The FSM, matrix storage and MAC stay in uart_matmul_top.

Test Plan:
- N=2 at 9600 baud (b_sel=01):
  - Send 02, A=01 02 03 04, B=05 06 07 08.
  - tx emits 00 00 13, 00 00 16, 00 00 2B, 00 00 32.
- N=3 at 9600 baud:
  - Send 03, A=01 02 03 04 03 04 04 03 04, B=05 06 07 08 07 08 08 07 08.
  - C = 45 41 47 / 76 73 84 / 76 73 84.
  - tx emits 00 00 2D, 00 00 29, 00 00 2F, 00 00 4C, 00 00 49, 00 00 54, 00 00 4C, 00 00 49, 00 00 54.
- Max values:
  - N=1, A=FF, B=FF -> 00 FE 01.
  - N=3, all bytes FF -> nine repetitions of 02 FA 03.
- Illegal size:
  - Send 00, then 07; both are ignored.
  - Then send 01, 03, 05 -> 00 00 0F.
- Reset mid-load:
  - Assert rst after 4 bytes of A; tx stays 1.
  - A fresh N=2 transaction then yields 00 00 13, 00 00 16, 00 00 2B, 00 00 32.
- 115200 baud (b_sel=11):
  - Repeat the N=2 case; the same bytes appear at 434 clocks/bit.
